// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE;
  endfunction

  // Index counter width; never narrower than one bit, even for a single nibble.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// Combinational 4-bit carry-lookahead slice; exposes the carry into bit 3
// so the caller can derive signed overflow on the top nibble.
module cla_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g, p and cin (no rippling).
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit adder/subtractor that reuses one 4-bit CLA slice, one nibble per
// clock, LSB first, with a start/busy/done handshake and registered outputs.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Q,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH:0]     q_q, q_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [3:0]         nib_s;
  logic               nib_cout;
  logic               nib_c3;
  logic [WIDTH+3:0]   res_cat;

  // Operands shift right each RUN cycle, so the slice always sees bits [3:0].
  cla_slice_4 u_cla (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  // New sum nibble enters at the top; after NIB shifts it lands in place.
  assign res_cat = {nib_s, res_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    q_d     = q_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = nib_cout;
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        res_d   = res_cat[WIDTH+3:4];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          q_d     = {nib_cout, res_d};
          ovf_d   = nib_c3 ^ nib_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub: 16-bit vector table plus
// hand-written sequences, and a 4-bit instance for the single-nibble case.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub;
  logic [15:0] A, B;
  logic        busy, done, ovf;
  logic [16:0] Q;

  logic        start4, sub4;
  logic [3:0]  A4, B4;
  logic        busy4, done4, ovf4;
  logic [4:0]  Q4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .ovf(ovf)
  );

  nibble_serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .Q(Q4), .ovf(ovf4)
  );

  typedef struct {
    string       name;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] q;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch one operation and follow it cycle by cycle to its done pulse.
  task automatic run_op(input string nm, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [16:0] eq, input logic eo);
    @(negedge clk);
    start = 1'b1; sub = s; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; sub = ~s;
    chk({nm, " busy@E0"}, busy, 1);
    chk({nm, " done@E0"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " busy@E3"}, busy, 1);
    @(posedge clk); #1;
    chk({nm, " done@E4"}, done, 1);
    chk({nm, " busy@E4"}, busy, 0);
    chk({nm, " Q"}, Q, eq);
    chk({nm, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    chk({nm, " done@E5"}, done, 0);
    chk({nm, " Qhold"}, Q, eq);
  endtask

  initial begin
    vecs[0] = '{"add1234", 1'b0, 16'h1234, 16'h4321, 17'h05555, 1'b0};
    vecs[1] = '{"addFFFF", 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
    vecs[2] = '{"add7FFF", 1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
    vecs[3] = '{"sub5m3",  1'b1, 16'h0005, 16'h0003, 17'h10002, 1'b0};
    vecs[4] = '{"sub3m5",  1'b1, 16'h0003, 16'h0005, 17'h0FFFE, 1'b0};
    vecs[5] = '{"sub8000", 1'b1, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
    vecs[6] = '{"add8000", 1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1};
    vecs[7] = '{"sub0m0",  1'b1, 16'h0000, 16'h0000, 17'h10000, 1'b0};

    reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    start4 = 1'b0; sub4 = 1'b0; A4 = '0; B4 = '0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst Q",    Q,    0);
    chk("rst ovf",  ovf,  0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf);

    // start mid-RUN is ignored; then start in DONE chains a second op.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 16'h1234; B = 16'h4321;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b1; A = 16'hFFFF; B = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrun busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("midrun done", done, 1);
    chk("midrun Q",    Q,    17'h05555);
    start = 1'b1; sub = 1'b1; A = 16'h0005; B = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b done drop", done, 0);
    chk("b2b busy",      busy, 1);
    chk("b2b Qheld",     Q,    17'h05555);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b done early", done, 0);
    @(posedge clk); #1;
    chk("b2b done", done, 1);
    chk("b2b Q",    Q,    17'h10002);

    // Reset at RUN cycle 2 aborts the op immediately.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 16'h7FFF; B = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort Q",    Q,    0);
    chk("abort done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort nodone", done, 0);
    end
    run_op("after abort", 1'b0, 16'hA5A5, 16'h1111, 17'h0B6B6, 1'b0);

    // Single-nibble instance.
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; A4 = 4'hF; B4 = 4'h1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("w4 busy", busy4, 1);
    chk("w4 done@E0", done4, 0);
    @(posedge clk); #1;
    chk("w4 done", done4, 1);
    chk("w4 Q",    Q4,    5'h10);
    chk("w4 ovf",  ovf4,  0);
    @(posedge clk); #1;
    chk("w4 done drop", done4, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
